clock_counter_mem: RTL and testbench
====================================

CLOCK_COUNTER_MEM -- requirements
Module: clock_counter_mem

Interface
REQ-001 SHALL have parameter AW, default 15: word-address width; depth is 2**AW 16-bit words.
REQ-002 SHALL have parameter MAX_CYCLES, default 32'd1000: cycle count at which timeout asserts.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1: reset, asynchronous and active-low.
REQ-005 SHALL have port halt  in  1: freezes the cycle counter and blocks writes while 1.
REQ-006 SHALL have port raddr0  in  AW: word address, read port 0 (instruction fetch).
REQ-007 SHALL have port rdata0  out  16: read data, port 0.
REQ-008 SHALL have port raddr1  in  AW: word address, read port 1 (data load).
REQ-009 SHALL have port rdata1  out  16: read data, port 1.
REQ-010 SHALL have port wen  in  1: write enable.
REQ-011 SHALL have port waddr  in  AW: write word address.
REQ-012 SHALL have port wdata  in  16: write data.
REQ-013 SHALL have port dbg_addr  in  AW: debug peek address.
REQ-014 SHALL have port dbg_data  out  16: debug peek data.
REQ-015 SHALL have port cycle_count  out  32: cycles elapsed while not halted.
REQ-016 SHALL have port timeout  out  1: sticky; high once cycle_count reaches MAX_CYCLES.

Function
REQ-017 SHALL register rdata0, rdata1 and dbg_data: address sampled at edge N, data valid after edge N (1-cycle latency).
REQ-018 SHALL write wdata to mem[waddr] at a rising edge when wen=1 and halt=0; with halt=1 the write is dropped.
REQ-019 SHALL, when a read address equals waddr during an effective write, return the old contents (read-before-write) unless RD_BYPASS_EN is defined.
REQ-020 SHALL serve both read ports and the debug port independently in the same cycle, including identical addresses.
REQ-021 SHALL increment cycle_count by 1 each edge with halt=0, hold it with halt=1, and wrap 32'hFFFFFFFF to 0.
REQ-022 SHALL set timeout at the edge where cycle_count becomes MAX_CYCLES and hold it until reset; counting continues.
REQ-023 SHALL keep reads active while halt=1.

Reset
REQ-024 SHALL, on rst_n low, immediately clear rdata0, rdata1, dbg_data, cycle_count and timeout to 0.
REQ-025 SHALL NOT reset memory array contents; contents are undefined until written.
REQ-026 SHALL ignore wen while rst_n is low; a reset mid-write leaves the target word unspecified.

Configuration
REQ-027 SHALL honour macro RD_BYPASS_EN: when defined, any read port whose address matches an effective write returns wdata that cycle; when undefined, it returns the old word.

Structure
REQ-028 SHALL place the data width (16), default AW and default MAX_CYCLES in shared package ccm_pkg.
REQ-029 SHALL implement the storage array as sub-module ccm_ram (1 write, 3 registered read ports); the counter and timeout stay in the top module.

Verification
REQ-030 SHALL cover: reset, write 0x1234 to addr 5, read port 0 addr 5 -> rdata0=0x1234 one cycle later.
REQ-031 SHALL cover: halt=1, wen=1, addr 7 data 0xBEEF -> addr 7 unchanged; cycle_count held.
REQ-032 SHALL cover: write 0xAAAA then 0x5555 to addr 3 while reading addr 3 -> 0xAAAA without RD_BYPASS_EN, 0x5555 with it.
REQ-033 SHALL cover: MAX_CYCLES=10, halt=0 for 12 cycles -> timeout rises at count 10, count=12, timeout stays 1.
REQ-034 SHALL cover: rst_n low mid-simulation between clock edges -> cycle_count, timeout and all rdata go to 0 immediately.
REQ-035 SHALL cover: raddr0=raddr1=dbg_addr=9 holding 0x00FF -> all three outputs 0x00FF.

Source files
------------

// File: rtl/ccm_pkg.sv
// ccm_pkg: shared widths and defaults for the clock counter memory.
package ccm_pkg;
   localparam int          DW             = 16;
   localparam int          AW_DEF         = 15;
   localparam logic [31:0] MAX_CYCLES_DEF = 32'd1000;
   typedef logic [DW-1:0] word_t;
endpackage

// File: rtl/clock_counter_mem_if.sv
// clock_counter_mem_if: two read ports, debug peek and write port bundled.
interface clock_counter_mem_if import ccm_pkg::*; #(parameter int AW = AW_DEF);
   logic [AW-1:0] raddr0, raddr1, waddr, dbg_addr;
   logic          wen;
   word_t         wdata, rdata0, rdata1, dbg_data;
   modport master (output raddr0, raddr1, wen, waddr, wdata, dbg_addr,
                   input  rdata0, rdata1, dbg_data);
   modport slave  (input  raddr0, raddr1, wen, waddr, wdata, dbg_addr,
                   output rdata0, rdata1, dbg_data);
endinterface

// File: rtl/ccm_ram.sv
// ccm_ram: 1 write / 3 registered read port array; RD_BYPASS_EN forwards write data.
module ccm_ram import ccm_pkg::*; #(parameter int AW = AW_DEF) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  word_t         wdata,
   input  logic [AW-1:0] raddr0,
   input  logic [AW-1:0] raddr1,
   input  logic [AW-1:0] raddr2,
   output word_t         rdata0,
   output word_t         rdata1,
   output word_t         rdata2
);
`ifdef RD_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif
   word_t mem [2**AW];
   word_t nxt0, nxt1, nxt2;
   assign nxt0 = (BYPASS && we && raddr0 == waddr) ? wdata : mem[raddr0];
   assign nxt1 = (BYPASS && we && raddr1 == waddr) ? wdata : mem[raddr1];
   assign nxt2 = (BYPASS && we && raddr2 == waddr) ? wdata : mem[raddr2];
   // array itself is never reset
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rdata0 <= '0;
         rdata1 <= '0;
         rdata2 <= '0;
      end else begin
         rdata0 <= nxt0;
         rdata1 <= nxt1;
         rdata2 <= nxt2;
      end
endmodule

// File: rtl/clock_counter_mem.sv
// clock_counter_mem: memory with halt-gated writes, cycle counter and sticky timeout.
// Define RD_BYPASS_EN to forward write data to matching reads in the same cycle.
module clock_counter_mem import ccm_pkg::*; #(
   parameter int          AW         = AW_DEF,
   parameter logic [31:0] MAX_CYCLES = MAX_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 halt,
   clock_counter_mem_if.slave   bus,
   output logic [31:0]          cycle_count,
   output logic                 timeout
);
   logic        we;
   logic [31:0] cnt_nxt;
   assign we      = bus.wen & ~halt & rst_n;
   assign cnt_nxt = cycle_count + 32'd1;
   ccm_ram #(.AW(AW)) u_ram (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (we),
      .waddr  (bus.waddr),
      .wdata  (bus.wdata),
      .raddr0 (bus.raddr0),
      .raddr1 (bus.raddr1),
      .raddr2 (bus.dbg_addr),
      .rdata0 (bus.rdata0),
      .rdata1 (bus.rdata1),
      .rdata2 (bus.dbg_data)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cycle_count <= '0;
         timeout     <= 1'b0;
      end else if (!halt) begin
         cycle_count <= cnt_nxt;
         timeout     <= timeout | (cnt_nxt == MAX_CYCLES);
      end
endmodule

// File: tb/tb_clock_counter_mem.sv
// tb_clock_counter_mem: directed scoreboard bench for clock_counter_mem.
module tb_clock_counter_mem;
   import ccm_pkg::*;
   localparam int AW = 15;
`ifdef RD_BYPASS_EN
   localparam logic [15:0] RBW_EXP = 16'h5555;
`else
   localparam logic [15:0] RBW_EXP = 16'hAAAA;
`endif
   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;
   logic        clk = 1'b0;
   logic        rst_n, halt;
   logic [31:0] cycle_count;
   logic        timeout;
   int          vectors = 0, miscompares = 0;
   int          exp_cnt = 0;
   logic        exp_to = 1'b0;
   sb_t         q[$];
   clock_counter_mem_if #(.AW(AW)) bus ();
   clock_counter_mem #(.AW(AW), .MAX_CYCLES(32'd10)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .halt        (halt),
      .bus         (bus),
      .cycle_count (cycle_count),
      .timeout     (timeout)
   );
   always #5 clk = ~clk;
   task automatic tick();
      if (rst_n && !halt) begin
         exp_cnt++;
         if (exp_cnt == 10) exp_to = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask
   task automatic push(input string t, input logic [31:0] e);
      q.push_back('{t, e});
   endtask
   task automatic pop(input logic [31:0] obs);
      sb_t e;
      if (q.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty observed=%h expected=entry", obs);
         return;
      end
      e = q.pop_front();
      vectors++;
      assert (obs === e.exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
   endtask
   task automatic chk_ctr();
      push("cycle_count", exp_cnt);
      pop(cycle_count);
      push("timeout", {31'd0, exp_to});
      pop({31'd0, timeout});
   endtask
   task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
      bus.wen = 1'b1; bus.waddr = a; bus.wdata = d;
      tick();
      bus.wen = 1'b0;
   endtask
   initial begin
      rst_n = 1'b0; halt = 1'b0;
      bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0;
      bus.raddr0 = '0; bus.raddr1 = '0; bus.dbg_addr = '0;
      repeat (3) tick();
      push("rst_rdata0", 0); push("rst_rdata1", 0); push("rst_dbg", 0);
      pop(bus.rdata0); pop(bus.rdata1); pop(bus.dbg_data);
      chk_ctr();
      rst_n = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         push("to_rise", (i >= 10) ? 32'd1 : 32'd0);
         pop({31'd0, timeout});
         chk_ctr();
      end
      push("count_12", 32'd12);
      pop(cycle_count);
      wr(15'd5, 16'h1234);
      bus.raddr0 = 15'd5;
      push("rd0_a5", 16'h1234);
      tick();
      pop(bus.rdata0);
      wr(15'd7, 16'h0777);
      halt = 1'b1;
      bus.wen = 1'b1; bus.waddr = 15'd7; bus.wdata = 16'hBEEF;
      bus.raddr0 = 15'd7;
      push("halt_rd_a7", 16'h0777);
      tick();
      pop(bus.rdata0);
      push("halt_drop_a7", 16'h0777);
      tick();
      pop(bus.rdata0);
      chk_ctr();
      bus.wen = 1'b0; halt = 1'b0;
      wr(15'd3, 16'hAAAA);
      bus.wen = 1'b1; bus.waddr = 15'd3; bus.wdata = 16'h5555;
      bus.raddr0 = 15'd3; bus.raddr1 = 15'd3; bus.dbg_addr = 15'd3;
      push("rbw_rd0", RBW_EXP); push("rbw_rd1", RBW_EXP); push("rbw_dbg", RBW_EXP);
      tick();
      pop(bus.rdata0); pop(bus.rdata1); pop(bus.dbg_data);
      bus.wen = 1'b0;
      push("after_rd0", 16'h5555);
      tick();
      pop(bus.rdata0);
      wr(15'd9, 16'h00FF);
      bus.raddr0 = 15'd9; bus.raddr1 = 15'd9; bus.dbg_addr = 15'd9;
      push("same_rd0", 16'h00FF); push("same_rd1", 16'h00FF); push("same_dbg", 16'h00FF);
      tick();
      pop(bus.rdata0); pop(bus.rdata1); pop(bus.dbg_data);
      bus.raddr0 = 15'd5; bus.raddr1 = 15'd9; bus.dbg_addr = 15'd3;
      push("ind_rd0", 16'h1234); push("ind_rd1", 16'h00FF); push("ind_dbg", 16'h5555);
      tick();
      pop(bus.rdata0); pop(bus.rdata1); pop(bus.dbg_data);
      chk_ctr();
      #2 rst_n = 1'b0;
      exp_cnt = 0; exp_to = 1'b0;
      #1;
      push("arst_rd0", 0); push("arst_rd1", 0); push("arst_dbg", 0);
      pop(bus.rdata0); pop(bus.rdata1); pop(bus.dbg_data);
      chk_ctr();
      #1 rst_n = 1'b1;
      bus.raddr0 = 15'd5;
      push("keep_a5", 16'h1234);
      tick();
      pop(bus.rdata0);
      chk_ctr();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
